i2s_receiver: RTL and testbench

I2S_RECEIVER -- requirements
Module: i2s_receiver

---
 rtl/i2s_receiver.sv | 97 +++++++++
 tb/tb_i2s_receiver.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/i2s_receiver.sv
// i2s_receiver: oversampling I2S slave that deserialises left/right words into the clk domain
module i2s_receiver #(
  parameter int SAMPLE_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    bit_clk,
  input  logic                    frame_clk,
  input  logic                    data,
  output logic [SAMPLE_WIDTH-1:0] sample_left,
  output logic [SAMPLE_WIDTH-1:0] sample_right,
  output logic                    sample_valid,
  output logic                    frame_error,
  output logic                    locked
);
  localparam int CW = $clog2(SAMPLE_WIDTH + 1);
  localparam logic [CW-1:0] FULL = CW'(SAMPLE_WIDTH);
  typedef enum logic {IDLE, RECV} state_t;
  state_t state;
  logic [2:0] bck_s;
  logic [1:0] fs_s, d_s;
  logic primed, prev_fs, chan, have_l;
  logic [CW-1:0] cnt;
  logic [SAMPLE_WIDTH-1:0] sh, pend_l, nsh;
  logic brise, fs, trans, take, full_now;
  assign brise = bck_s[1] & ~bck_s[2];
  assign fs = fs_s[1];
  // the very first brise after reset only records frame_clk; it cannot be a transition
  assign trans = primed && (fs != prev_fs);
  assign take = cnt < FULL;
  assign full_now = take && (cnt + 1'b1 == FULL);
  assign nsh = {sh[SAMPLE_WIDTH-2:0], d_s[1]};
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      bck_s <= '0;
      fs_s <= '0;
      d_s <= '0;
      primed <= 1'b0;
      prev_fs <= 1'b0;
      chan <= 1'b0;
      have_l <= 1'b0;
      cnt <= '0;
      sh <= '0;
      pend_l <= '0;
      sample_left <= '0;
      sample_right <= '0;
      sample_valid <= 1'b0;
      frame_error <= 1'b0;
      locked <= 1'b0;
    end else begin
      bck_s <= {bck_s[1:0], bit_clk};
      fs_s <= {fs_s[0], frame_clk};
      d_s <= {d_s[0], data};
      sample_valid <= 1'b0;
      frame_error <= 1'b0;
      if (brise) begin
        primed <= 1'b1;
        prev_fs <= fs;
        if (state == IDLE) begin
          if (trans) begin
            state <= RECV;
            locked <= 1'b1;
            cnt <= '0;
            sh <= '0;
            chan <= fs;
          end
        end else begin
          if (take) begin
            sh <= nsh;
            cnt <= cnt + 1'b1;
          end
          if (full_now) begin
            if (!chan) begin
              pend_l <= nsh;
              have_l <= 1'b1;
            end else if (have_l) begin
              sample_left <= pend_l;
              sample_right <= nsh;
              sample_valid <= 1'b1;
              have_l <= 1'b0;
            end else begin
              frame_error <= 1'b1;
            end
          end
          // bit taken at a transition is the old slot's LSB, so the short-slot check follows the shift
          if (trans) begin
            if (take && !full_now) frame_error <= 1'b1;
            cnt <= '0;
            sh <= '0;
            chan <= fs;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_i2s_receiver.sv
// tb_i2s_receiver: directed I2S frames against hand-computed words and pulse counts
module tb_i2s_receiver;
  logic clk = 1'b0, reset = 1'b0, bit_clk = 1'b0, frame_clk = 1'b0, data = 1'b0;
  logic [15:0] sample_left, sample_right;
  logic sample_valid, frame_error, locked;
  int total = 0, bad = 0, nvalid = 0, nerr = 0, dbl = 0, half = 3;
  int v0, e0;
  logic pv = 1'b0, pe = 1'b0, prev_bit = 1'b0, started = 1'b0;
  logic [31:0] q[$];
  logic [31:0] exp_pair;
  logic [15:0] wl, wr;

  i2s_receiver #(.SAMPLE_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .bit_clk(bit_clk), .frame_clk(frame_clk), .data(data),
    .sample_left(sample_left), .sample_right(sample_right),
    .sample_valid(sample_valid), .frame_error(frame_error), .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if ((sample_valid && pv) || (frame_error && pe)) dbl++;
    pv <= sample_valid;
    pe <= frame_error;
    if (frame_error) nerr++;
    if (sample_valid) begin
      nvalid++;
      if (q.size() > 0) begin
        exp_pair = q.pop_front();
        chk("pair", {sample_left, sample_right}, exp_pair);
      end
    end
  end

  task automatic send_bit(input logic f, input logic d);
    frame_clk = f;
    data = d;
    #(half * 10) bit_clk = 1'b1;
    #(half * 10) bit_clk = 1'b0;
  endtask

  // data lags frame_clk by one bit: each slot's LSB rides on the next slot's first bit
  task automatic send_slot(input logic ch, input logic [15:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      if (!(started && i == 0)) send_bit(ch, prev_bit);
      prev_bit = (i < 16) ? w[15 - i] : 1'b1;
    end
    started = 1'b0;
  endtask

  task automatic flush();
    send_bit(1'b0, prev_bit);
    started = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_out(input string tag, input logic [15:0] l, input logic [15:0] r, input logic lk);
    chk({tag, "_left"}, 32'(sample_left), 32'(l));
    chk({tag, "_right"}, 32'(sample_right), 32'(r));
    chk({tag, "_locked"}, 32'(locked), 32'(lk));
  endtask

  initial begin
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_out("reset", 16'h0, 16'h0, 1'b0);
    chk("reset_valid", 32'(sample_valid), 32'h0);
    chk("reset_err", 32'(frame_error), 32'h0);
    @(posedge clk);
    #1 reset = 1'b1;

    v0 = nvalid; e0 = nerr;
    send_slot(1'b0, 16'hFFFF, 5);
    send_slot(1'b1, 16'h1234, 16);
    chk("partial_err", 32'(nerr - e0), 32'd0);
    chk("partial_valid", 32'(nvalid - v0), 32'd0);
    chk("partial_locked", 32'(locked), 32'h1);
    for (int k = 0; k < 2; k++) begin
      send_slot(1'b0, 16'hA5C3, 16);
      send_slot(1'b1, 16'h1234, 16);
    end
    flush();
    check_out("basic", 16'hA5C3, 16'h1234, 1'b1);
    chk("basic_valid", 32'(nvalid - v0), 32'd2);
    chk("basic_err", 32'(nerr - e0), 32'd1);

    v0 = nvalid; e0 = nerr;
    send_slot(1'b0, 16'hFFFF, 10);
    send_slot(1'b1, 16'h5555, 16);
    flush();
    chk("short_err", 32'(nerr - e0), 32'd2);
    chk("short_valid", 32'(nvalid - v0), 32'd0);
    check_out("short", 16'hA5C3, 16'h1234, 1'b1);

    v0 = nvalid; e0 = nerr;
    send_slot(1'b0, 16'h8001, 32);
    send_slot(1'b1, 16'h8001, 32);
    flush();
    check_out("long", 16'h8001, 16'h8001, 1'b1);
    chk("long_valid", 32'(nvalid - v0), 32'd1);
    chk("long_err", 32'(nerr - e0), 32'd0);

    send_slot(1'b0, 16'hA5C3, 16);
    send_slot(1'b1, 16'h1234, 8);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check_out("midrst", 16'h0, 16'h0, 1'b0);
    v0 = nvalid; e0 = nerr;
    send_slot(1'b1, 16'h0000, 8);
    send_slot(1'b0, 16'hA5C3, 16);
    send_slot(1'b1, 16'h1234, 16);
    flush();
    check_out("resume", 16'hA5C3, 16'h1234, 1'b1);
    chk("resume_valid", 32'(nvalid - v0), 32'd1);
    chk("resume_err", 32'(nerr - e0), 32'd0);

    half = 2;
    #($urandom_range(1, 9));
    v0 = nvalid; e0 = nerr;
    for (int k = 0; k < 100; k++) begin
      wl = 16'($urandom);
      wr = 16'($urandom);
      q.push_back({wl, wr});
      send_slot(1'b0, wl, 16);
      send_slot(1'b1, wr, 16);
    end
    flush();
    chk("rand_valid", 32'(nvalid - v0), 32'd100);
    chk("rand_err", 32'(nerr - e0), 32'd0);
    chk("rand_left_over", 32'(q.size()), 32'd0);
    chk("pulse_width", 32'(dbl), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
